dds_ram_reader: RTL and testbench

Read-side controller for the single-port DDS waveform RAM (3 tables × 1024 words, 12-bit address, 32-bit data, 1-cycle registered read).
- Runs a phase accumulator and converts phase to a table address with a per-table offset.
- Issues read-only accesses to the RAM and re-times the returned words into a sample stream with a valid flag.
- Sits between the host configuration registers and the DAC/sample sink.

---
 rtl/dds_ram_reader.sv | 128 ++++++++++++
 tb/tb_dds_ram_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_ram_reader.sv
// Phase accumulator driving reads of a 3-table DDS RAM. A sample reaches sample_out 2 edges after its address.
// Config changes wait for a waveform wrap so the running period is never corrupted. There is no backpressure.
module dds_ram_reader #(
   parameter int PHASE_WIDTH = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_WAVES   = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   cfg_load,
   input  logic [PHASE_WIDTH-1:0] fcw_in,
   input  logic [ADDR_WIDTH-1:0]  poff_in,
   input  logic [1:0]             wave_sel_in,
   output logic [11:0]            ram_addr,
   output logic                   ram_wrn,
   input  logic [DATA_WIDTH-1:0]  ram_dout,
   output logic [DATA_WIDTH-1:0]  sample_out,
   output logic                   sample_valid,
   output logic                   cycle_done
);

   localparam int FULL_AW = ADDR_WIDTH + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state;
   logic                   drain_cnt;
   logic [PHASE_WIDTH-1:0] acc;
   logic [PHASE_WIDTH-1:0] fcw_act;
   logic [PHASE_WIDTH-1:0] fcw_pend;
   logic [ADDR_WIDTH-1:0]  poff_act;
   logic [ADDR_WIDTH-1:0]  poff_pend;
   logic [1:0]             sel_act;
   logic [1:0]             sel_pend;
   logic                   pend;
   logic [1:0]             v_pipe;

   logic [PHASE_WIDTH:0]   sum_full;
   logic                   issue;
   logic                   wrap;
   logic                   apply;
   logic [ADDR_WIDTH-1:0]  idx;
   logic [1:0]             sel;
   logic [FULL_AW-1:0]     addr_full;
   logic [11:0]            addr_nxt;

   assign sum_full  = {1'b0, acc} + {1'b0, fcw_act};
   assign issue     = (state == RUN) && en;
   assign wrap      = issue && sum_full[PHASE_WIDTH];
   // Applying only at a wrap (or while idle) keeps each period at a single step size.
   assign apply     = pend && ((state == IDLE) || wrap);
   assign idx       = acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + poff_act;
   assign sel       = (int'(sel_act) < NUM_WAVES) ? sel_act : 2'd0;
   assign addr_full = {sel, idx};
   assign addr_nxt  = 12'(addr_full);
   assign ram_wrn   = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         drain_cnt    <= 1'b0;
         acc          <= '0;
         fcw_act      <= '0;
         fcw_pend     <= '0;
         poff_act     <= '0;
         poff_pend    <= '0;
         sel_act      <= '0;
         sel_pend     <= '0;
         pend         <= 1'b0;
         v_pipe       <= '0;
         ram_addr     <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         cycle_done   <= 1'b0;
      end else begin
         if (cfg_load) begin
            fcw_pend  <= fcw_in;
            poff_pend <= poff_in;
            sel_pend  <= wave_sel_in;
         end
         // A load on the apply edge re-arms pending for the next opportunity.
         if (cfg_load)
            pend <= 1'b1;
         else if (apply)
            pend <= 1'b0;
         if (apply) begin
            fcw_act  <= fcw_pend;
            poff_act <= poff_pend;
            sel_act  <= sel_pend;
         end

         if (issue) begin
            acc      <= sum_full[PHASE_WIDTH-1:0];
            ram_addr <= addr_nxt;
         end
         cycle_done   <= wrap;
         v_pipe       <= {v_pipe[0], issue};
         sample_valid <= v_pipe[1];
         if (v_pipe[1])
            sample_out <= ram_dout;

         case (state)
            IDLE: begin
               if (en)
                  state <= RUN;
            end
            RUN: begin
               if (!en) begin
                  state     <= DRAIN;
                  drain_cnt <= 1'b0;
               end
            end
            DRAIN: begin
               if (en)
                  state <= RUN;
               else if (drain_cnt)
                  state <= IDLE;
               else
                  drain_cnt <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_ram_reader.sv
// Directed bench for dds_ram_reader with a RAM model whose word[a] = a.
module tb_dds_ram_reader;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        cfg_load;
   logic [31:0] fcw_in;
   logic [9:0]  poff_in;
   logic [1:0]  wave_sel_in;
   logic [11:0] ram_addr;
   logic        ram_wrn;
   logic [31:0] ram_dout;
   logic [31:0] sample_out;
   logic        sample_valid;
   logic        cycle_done;

   int total = 0;
   int bad   = 0;

   dds_ram_reader #(
      .PHASE_WIDTH(32),
      .ADDR_WIDTH (10),
      .DATA_WIDTH (32),
      .NUM_WAVES  (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cfg_load    (cfg_load),
      .fcw_in      (fcw_in),
      .poff_in     (poff_in),
      .wave_sel_in (wave_sel_in),
      .ram_addr    (ram_addr),
      .ram_wrn     (ram_wrn),
      .ram_dout    (ram_dout),
      .sample_out  (sample_out),
      .sample_valid(sample_valid),
      .cycle_done  (cycle_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial ram_dout = '0;
   always @(posedge clk) ram_dout <= {20'd0, ram_addr};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_cfg(input logic [31:0] f, input logic [9:0] p, input logic [1:0] s);
      fcw_in      = f;
      poff_in     = p;
      wave_sel_in = s;
      cfg_load    = 1'b1;
      step();
      cfg_load    = 1'b0;
   endtask

   task automatic do_reset();
      en       = 1'b0;
      cfg_load = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n    = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_smp"},  sample_out, 32'd0);
      chk({tag, "_vld"},  32'(sample_valid), 32'd0);
      chk({tag, "_done"}, 32'(cycle_done), 32'd0);
      chk({tag, "_wrn"},  32'(ram_wrn), 32'd0);
   endtask

   int exp3 [19] = '{0, 512, 0, 512, 0, 256, 512, 768, 0, 256,
                     512, 768, 0, 256, 512, 768, 0, 128, 256};

   initial begin
      rst_n       = 1'b0;
      en          = 1'b0;
      cfg_load    = 1'b0;
      fcw_in      = '0;
      poff_in     = '0;
      wave_sel_in = '0;

      // reset values
      @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;

      // linear ramp from table 0, then en drop and resume
      load_cfg(32'h0040_0000, 10'd0, 2'd0);
      step();
      en = 1'b1;
      step();
      for (int i = 0; i <= 10; i++) begin
         step();
         chk("s1_addr", 32'(ram_addr), 32'(i));
         chk("s1_vld", 32'(sample_valid), (i >= 2) ? 32'd1 : 32'd0);
         if (i >= 2) chk("s1_smp", sample_out, 32'(i - 2));
      end
      en = 1'b0;
      step();
      chk("drn_vld1", 32'(sample_valid), 32'd1);
      chk("drn_smp1", sample_out, 32'd9);
      chk("drn_addr", 32'(ram_addr), 32'd10);
      step();
      chk("drn_vld2", 32'(sample_valid), 32'd1);
      chk("drn_smp2", sample_out, 32'd10);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drn_vld0", 32'(sample_valid), 32'd0);
         chk("drn_hold", 32'(ram_addr), 32'd10);
      end
      en = 1'b1;
      step();
      chk("res_hold", 32'(ram_addr), 32'd10);
      step();
      chk("res_addr", 32'(ram_addr), 32'd11);
      do_reset();

      // table 2 with offset 5: wrap within the table, period 1024
      load_cfg(32'h0040_0000, 10'd5, 2'd2);
      step();
      en = 1'b1;
      step();
      for (int n = 0; n <= 2050; n++) begin
         step();
         chk("s2_addr", 32'(ram_addr), 32'(2048 + (n + 5) % 1024));
         chk("s2_done", 32'(cycle_done), (n % 1024 == 1023) ? 32'd1 : 32'd0);
      end
      do_reset();

      // step size changes only at a wrap; a load on the wrap edge waits a period
      load_cfg(32'h8000_0000, 10'd0, 2'd0);
      step();
      en = 1'b1;
      step();
      for (int n = 0; n < 19; n++) begin
         if (n == 2) begin
            fcw_in   = 32'h4000_0000;
            cfg_load = 1'b1;
         end else if (n == 11) begin
            fcw_in   = 32'h2000_0000;
            cfg_load = 1'b1;
         end
         step();
         cfg_load = 1'b0;
         chk("s3_addr", 32'(ram_addr), 32'(exp3[n]));
         chk("s3_done", 32'(cycle_done),
             (n == 1 || n == 3 || n == 7 || n == 11 || n == 15) ? 32'd1 : 32'd0);
      end
      do_reset();

      // fcw of zero: constant address, samples still stream
      load_cfg(32'd0, 10'd7, 2'd1);
      step();
      en = 1'b1;
      step();
      for (int n = 0; n < 6; n++) begin
         step();
         chk("z_addr", 32'(ram_addr), 32'd1031);
         chk("z_done", 32'(cycle_done), 32'd0);
         chk("z_vld", 32'(sample_valid), (n >= 2) ? 32'd1 : 32'd0);
         if (n >= 2) chk("z_smp", sample_out, 32'd1031);
      end
      do_reset();

      // invalid table select falls back to table 0; offset wraps inside it
      load_cfg(32'h0040_0000, 10'd1022, 2'd3);
      step();
      en = 1'b1;
      step();
      for (int n = 0; n < 6; n++) begin
         step();
         chk("s4_addr", 32'(ram_addr), 32'((1022 + n) % 1024));
         chk("s4_wrn", 32'(ram_wrn), 32'd0);
      end

      // reset mid-run with a pending config
      load_cfg(32'h0200_0000, 10'd100, 2'd1);
      en    = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_zero("arst");
      step();
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("post_vld", 32'(sample_valid), 32'd0);
         chk("post_addr", 32'(ram_addr), 32'd0);
      end
      en = 1'b1;
      step();
      for (int n = 0; n < 8; n++) begin
         step();
         chk("post_run_addr", 32'(ram_addr), 32'd0);
         chk("post_run_done", 32'(cycle_done), 32'd0);
         chk("post_run_vld", 32'(sample_valid), (n >= 2) ? 32'd1 : 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
